// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks register-file read port A over a fixed index
// range, waits for BusA to settle, and streams each value out on valid/ready.
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Abort,
  output logic [4:0]  RA,
  input  logic [63:0] BusA,
  output logic [63:0] DumpData,
  output logic [4:0]  DumpIdx,
  output logic        DumpValid,
  input  logic        DumpReady,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 64;
  // Counter holds READ_WAIT-1 at most; keep at least one bit when READ_WAIT==1.
  localparam int unsigned CNT_W  = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_PRESENT = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ra;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic [IDX_W-1:0]    r_idx;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_ra_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_valid_nxt;
  logic                w_accept;
  logic                w_last;

  assign w_accept = r_valid && DumpReady;
  assign w_last   = (r_ra == IDX_W'(LAST_REG));

  // Next-state and datapath update; Abort wins over acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_ra_nxt    = r_ra;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;

    case (r_state)
      S_IDLE: begin
        if (Start && !Abort) begin
          w_ra_nxt    = IDX_W'(FIRST_REG);
          w_cnt_nxt   = CNT_W'(READ_WAIT - 1);
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (Abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_data_nxt  = BusA;
          w_idx_nxt   = r_ra;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (Abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_valid_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_ra_nxt    = r_ra + IDX_W'(1);
            w_cnt_nxt   = CNT_W'(READ_WAIT - 1);
            w_state_nxt = S_SETUP;
          end
        end
      end
      S_FINISH: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; Busy/Done derive from the next state so they stay registered.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_ra    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ra    <= w_ra_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_FINISH);
    end
  end

  assign RA        = r_ra;
  assign DumpData  = r_data;
  assign DumpIdx   = r_idx;
  assign DumpValid = r_valid;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: two instances (default range, and a single
// register with READ_WAIT=1) checked against a beat-timing model every cycle.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [2];
  logic        start [2];
  logic        abort [2];
  logic        ready [2];
  logic [4:0]  ra    [2];
  logic [4:0]  idx   [2];
  logic [63:0] data  [2];
  logic [63:0] busa  [2];
  logic        valid [2];
  logic        busy  [2];
  logic        done  [2];

  logic [63:0] rf [2][32];

  assign busa[0] = rf[0][ra[0]];
  assign busa[1] = rf[1][ra[1]];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .READ_WAIT(2)) u_dut0 (
    .Clk(clk), .Resetn(rstn[0]), .Start(start[0]), .Abort(abort[0]),
    .RA(ra[0]), .BusA(busa[0]), .DumpData(data[0]), .DumpIdx(idx[0]),
    .DumpValid(valid[0]), .DumpReady(ready[0]), .Busy(busy[0]), .Done(done[0])
  );

  regfile_dump_reader #(.FIRST_REG(8), .LAST_REG(8), .READ_WAIT(1)) u_dut1 (
    .Clk(clk), .Resetn(rstn[1]), .Start(start[1]), .Abort(abort[1]),
    .RA(ra[1]), .BusA(busa[1]), .DumpData(data[1]), .DumpIdx(idx[1]),
    .DumpValid(valid[1]), .DumpReady(ready[1]), .Busy(busy[1]), .Done(done[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int cfg_first(int d); return (d == 0) ? 0 : 8; endfunction
  function automatic int cfg_last(int d);  return (d == 0) ? 31 : 8; endfunction
  function automatic int cfg_rw(int d);    return (d == 0) ? 2 : 1; endfunction

  function automatic logic [63:0] exp_data(int d, int i);
    if (d == 1) return (i == 8) ? 64'hDEAD_BEEF_0000_0008 : 64'h0;
    if (i == 31) return 64'h0;
    return 64'h1000 + 64'(i);
  endfunction

  // Model: a dump is "active" from Start to the final acceptance; beat i becomes
  // visible READ_WAIT posedges after RA moves to i; Done shows the cycle after
  // the final acceptance.
  int cyc = 0;
  bit m_active  [2];
  int m_idx     [2];
  int m_ready_at[2];
  int m_done_at [2];
  bit chk_en = 1'b0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_active[d]   = 1'b0;
      m_idx[d]      = 0;
      m_ready_at[d] = 0;
      m_done_at[d]  = -10;
    end
  end

  // Advance the model at each posedge using the inputs the DUT sees there.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        m_active[d]  = 1'b0;
        m_done_at[d] = -10;
      end else if (m_done_at[d] == cyc - 1) begin
        // finishing cycle: returns to idle whatever the inputs
      end else if (!m_active[d]) begin
        if (start[d] && !abort[d]) begin
          m_active[d]   = 1'b1;
          m_idx[d]      = cfg_first(d);
          m_ready_at[d] = cyc + cfg_rw(d);
        end
      end else if (abort[d]) begin
        m_active[d] = 1'b0;
      end else if ((cyc - 1 >= m_ready_at[d]) && ready[d]) begin
        if (m_idx[d] == cfg_last(d)) begin
          m_active[d]  = 1'b0;
          m_done_at[d] = cyc;
        end else begin
          m_idx[d]      = m_idx[d] + 1;
          m_ready_at[d] = cyc + cfg_rw(d);
        end
      end
    end
  end

  typedef struct {
    int          i;
    logic [63:0] dat;
    int          c;
  } beat_t;
  beat_t bq[$];
  int done_cnt[2] = '{0, 0};

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit ev, eb, ed;
        ev = m_active[d] && (cyc >= m_ready_at[d]);
        ed = (m_done_at[d] == cyc);
        eb = m_active[d] || ed;
        chk($sformatf("d%0d_valid@%0d", d, cyc), 64'(valid[d]), 64'(ev));
        chk($sformatf("d%0d_busy@%0d", d, cyc), 64'(busy[d]), 64'(eb));
        chk($sformatf("d%0d_done@%0d", d, cyc), 64'(done[d]), 64'(ed));
        if (ev) begin
          chk($sformatf("d%0d_idx@%0d", d, cyc), 64'(idx[d]), 64'(m_idx[d]));
          chk($sformatf("d%0d_data@%0d", d, cyc), data[d], exp_data(d, m_idx[d]));
        end
        if (m_active[d])
          chk($sformatf("d%0d_ra@%0d", d, cyc), 64'(ra[d]), 64'(m_idx[d]));
        if (done[d]) done_cnt[d]++;
      end
      if (valid[0] && ready[0] && !abort[0] && rstn[0])
        bq.push_back('{int'(idx[0]), data[0], cyc});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_ra"},    64'(ra[d]),    64'h0);
    chk({tag, "_data"},  data[d],       64'h0);
    chk({tag, "_idx"},   64'(idx[d]),   64'h0);
    chk({tag, "_valid"}, 64'(valid[d]), 64'h0);
    chk({tag, "_busy"},  64'(busy[d]),  64'h0);
    chk({tag, "_done"},  64'(done[d]),  64'h0);
  endtask

  int dc;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; start[d] = 1'b0; abort[d] = 1'b0; ready[d] = 1'b1;
      for (int i = 0; i < 32; i++) rf[d][i] = 64'h0;
    end
    for (int i = 0; i < 31; i++) rf[0][i] = 64'h1000 + 64'(i);
    rf[1][8] = 64'hDEAD_BEEF_0000_0008;

    repeat (3) tick;
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    chk_en = 1'b1;
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    tick;

    // Start together with Abort in IDLE stays idle
    start[0] = 1'b1; abort[0] = 1'b1;
    tick;
    start[0] = 1'b0; abort[0] = 1'b0;
    chk("idle_start_abort_busy", 64'(busy[0]), 64'h0);

    // Full dump with constant ready
    bq.delete();
    dc = done_cnt[0];
    start[0] = 1'b1; tick; start[0] = 1'b0;
    for (int i = 0; i < 200 && !done[0]; i++) tick;
    chk("runA_done_seen", 64'(done[0]), 64'h1);
    tick;
    chk("runA_done_count", 64'(done_cnt[0] - dc), 64'h1);
    chk("runA_beats", 64'(bq.size()), 64'd32);
    if (bq.size() == 32) begin
      chk("runA_b0_idx",   64'(bq[0].i), 64'h0);
      chk("runA_b0_data",  bq[0].dat,    64'h1000);
      chk("runA_b30_data", bq[30].dat,   64'h101E);
      chk("runA_b31_idx",  64'(bq[31].i), 64'd31);
      chk("runA_b31_data", bq[31].dat,   64'h0);
      chk("runA_space01",  64'(bq[1].c - bq[0].c), 64'd3);
      chk("runA_space3031", 64'(bq[31].c - bq[30].c), 64'd3);
    end

    // Re-Start while busy at index 3, then backpressure on beat 5
    bq.delete();
    dc = done_cnt[0];
    start[0] = 1'b1; tick; start[0] = 1'b0;
    for (int i = 0; i < 50 && ra[0] != 5'd3; i++) tick;
    chk("runB_ra3", 64'(ra[0]), 64'd3);
    start[0] = 1'b1; tick; start[0] = 1'b0;
    for (int i = 0; i < 50 && !(valid[0] && idx[0] == 5'd5); i++) tick;
    chk("runB_beat5_seen", 64'(valid[0] && idx[0] == 5'd5), 64'h1);
    ready[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("bp%0d_valid", k), 64'(valid[0]), 64'h1);
      chk($sformatf("bp%0d_data", k),  data[0],       64'h1005);
      chk($sformatf("bp%0d_idx", k),   64'(idx[0]),   64'd5);
      chk($sformatf("bp%0d_ra", k),    64'(ra[0]),    64'd5);
    end
    ready[0] = 1'b1;
    tick;
    for (int i = 0; i < 20 && !valid[0]; i++) tick;
    chk("runB_next_idx", 64'(idx[0]), 64'd6);
    for (int i = 0; i < 200 && !done[0]; i++) tick;
    chk("runB_done_seen", 64'(done[0]), 64'h1);
    tick;
    chk("runB_done_count", 64'(done_cnt[0] - dc), 64'h1);
    chk("runB_beats", 64'(bq.size()), 64'd32);

    // Abort while presenting beat 12, restart, then reset during SETUP of 20
    dc = done_cnt[0];
    start[0] = 1'b1; tick; start[0] = 1'b0;
    for (int i = 0; i < 100 && !(valid[0] && idx[0] == 5'd12); i++) tick;
    chk("runC_beat12_seen", 64'(valid[0] && idx[0] == 5'd12), 64'h1);
    abort[0] = 1'b1; tick; abort[0] = 1'b0;
    chk("abort_valid", 64'(valid[0]), 64'h0);
    chk("abort_busy",  64'(busy[0]),  64'h0);
    chk("abort_done",  64'(done[0]),  64'h0);
    start[0] = 1'b1; tick; start[0] = 1'b0;
    for (int i = 0; i < 20 && !valid[0]; i++) tick;
    chk("restart_idx",  64'(idx[0]), 64'h0);
    chk("restart_data", data[0],     64'h1000);
    for (int i = 0; i < 100 && !(ra[0] == 5'd20 && busy[0] && !valid[0]); i++) tick;
    chk("runC_setup20", 64'(ra[0] == 5'd20 && !valid[0]), 64'h1);
    rstn[0] = 1'b0; start[0] = 1'b1;
    tick;
    chk_reset(0, "midrst");
    rstn[0] = 1'b1; start[0] = 1'b0;
    tick;
    chk("midrst_start_ignored", 64'(busy[0]), 64'h0);
    chk("runC_no_done", 64'(done_cnt[0] - dc), 64'h0);

    // Single-register dump, READ_WAIT=1
    start[1] = 1'b1; tick; start[1] = 1'b0;
    chk("one_busy_setup",  64'(busy[1]),  64'h1);
    chk("one_valid_setup", 64'(valid[1]), 64'h0);
    tick;
    chk("one_valid", 64'(valid[1]), 64'h1);
    chk("one_idx",   64'(idx[1]),   64'd8);
    chk("one_data",  data[1],       64'hDEAD_BEEF_0000_0008);
    tick;
    chk("one_done",        64'(done[1]),  64'h1);
    chk("one_valid_fin",   64'(valid[1]), 64'h0);
    chk("one_busy_fin",    64'(busy[1]),  64'h1);
    tick;
    chk("one_done_after",  64'(done[1]),  64'h0);
    chk("one_busy_after",  64'(busy[1]),  64'h0);

    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
